// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial stimulus generator.
// The LFSR step function is used only when SEQ_BIT_GEN_LFSR_EN is defined.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'h0001;
  localparam int          RUN_LEN_DEF   = 4;

  // Right-shifting Fibonacci form: bit 0 is the output end, so the tap mask is mirrored.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] w_mask;
    for (int unsigned i = 0; i < 16; i++) w_mask[i] = LFSR_TAPS[15 - i];
    return {^(s & w_mask), s[15:1]};
  endfunction

endpackage

// File: rtl/seq_bit_gen_run_len_tracker.sv
// Tracks the run of identical valid bits; expect_s is registered so it
// lines up with the registered serial bit it describes.
module run_len_tracker
  import seq_gen_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic vld,
  input  logic in_bit,
  output logic expect_s
);

  localparam int CW = $clog2(RUN_LEN + 1);

  logic [CW-1:0] r_cnt;
  logic          r_prev;
  logic [CW-1:0] w_cnt;

  always_comb begin
    if (clr || (r_cnt == '0) || (in_bit != r_prev)) w_cnt = CW'(1);
    else if (r_cnt == CW'(RUN_LEN))                 w_cnt = r_cnt;
    else                                            w_cnt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !vld) begin
      r_cnt    <= '0;
      r_prev   <= 1'b0;
      expect_s <= 1'b0;
    end else begin
      r_cnt    <= w_cnt;
      r_prev   <= in_bit;
      expect_s <= (w_cnt == CW'(RUN_LEN));
    end
  end

endmodule

// File: rtl/seq_bit_gen.sv
// Serial stimulus transmitter: shifts a pattern out LSB-first with golden run-detector output.
// Optional LFSR source enabled by defining SEQ_BIT_GEN_LFSR_EN (adds port lfsr_mode).
module seq_bit_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W   = 16,
  parameter int CNT_W   = 5,
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef SEQ_BIT_GEN_LFSR_EN
  input  logic             lfsr_mode,
`endif
  input  logic             start,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [CNT_W-1:0] pat_len,
  input  logic             repeat_en,
  input  logic             stop,
  output logic             out_x,
  output logic             out_vld,
  output logic             expect_s,
  output logic [CNT_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [CNT_W-1:0] r_last_idx;
  logic             r_stop_seen;

  logic             w_start_acc;
  logic             w_last;
  logic             w_wrap;
  logic             w_next_vld;
  logic             w_next_bit;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_next_idx;
  logic [PAT_W-1:0] w_sel;

`ifdef SEQ_BIT_GEN_LFSR_EN
  logic             r_lfsr_mode;
  logic [15:0]      r_lfsr;
  logic [15:0]      w_seed;
`endif

  // Next-bit values are computed combinationally so out_x and the tracker update together.
  always_comb begin
    w_len       = ((pat_len == '0) || (pat_len > CNT_W'(PAT_W))) ? CNT_W'(PAT_W) : pat_len;
    w_start_acc = (r_state == IDLE) && start;
    w_last      = (r_state == SHIFT) && (bit_idx == r_last_idx);
    w_wrap      = w_last && repeat_en && !(r_stop_seen || stop);
    w_next_idx  = w_wrap ? '0 : bit_idx + 1'b1;
    w_next_vld  = w_start_acc || ((r_state == SHIFT) && (!w_last || w_wrap));
    w_sel       = w_start_acc ? pat_data : (r_pat >> w_next_idx);
    w_next_bit  = w_next_vld & w_sel[0];
`ifdef SEQ_BIT_GEN_LFSR_EN
    w_seed = (pat_data[15:0] == 16'h0000) ? LFSR_SEED_DEF : pat_data[15:0];
    if (w_start_acc ? lfsr_mode : r_lfsr_mode)
      w_next_bit = w_next_vld & (w_start_acc ? w_seed[0] : r_lfsr[0]);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pat       <= '0;
      r_last_idx  <= '0;
      r_stop_seen <= 1'b0;
      out_x       <= 1'b0;
      out_vld     <= 1'b0;
      bit_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SEQ_BIT_GEN_LFSR_EN
      r_lfsr_mode <= 1'b0;
      r_lfsr      <= LFSR_SEED_DEF;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          done    <= 1'b0;
          busy    <= w_start_acc;
          out_vld <= w_next_vld;
          out_x   <= w_next_bit;
          bit_idx <= '0;
          if (w_start_acc) begin
            r_state     <= SHIFT;
            r_pat       <= pat_data;
            r_last_idx  <= w_len - CNT_W'(1);
            r_stop_seen <= 1'b0;
`ifdef SEQ_BIT_GEN_LFSR_EN
            r_lfsr_mode <= lfsr_mode;
            r_lfsr      <= lfsr_step(w_seed);
`endif
          end
        end
        SHIFT: begin
          out_vld <= w_next_vld;
          out_x   <= w_next_bit;
          if (stop) r_stop_seen <= 1'b1;
          if (w_next_vld) begin
            bit_idx <= w_next_idx;
`ifdef SEQ_BIT_GEN_LFSR_EN
            r_lfsr  <= lfsr_step(r_lfsr);
`endif
          end else begin
            r_state <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          bit_idx <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  run_len_tracker #(
    .RUN_LEN(RUN_LEN)
  ) u_run_len_tracker (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_start_acc),
    .vld     (w_next_vld),
    .in_bit  (w_next_bit),
    .expect_s(expect_s)
  );

endmodule
